// File: rtl/s2a_src_if.sv
// Stream-side and 4-phase channel signals of s2a_src.
// master is the s2a_src side; slave is the producer plus asynchronous consumer.
interface s2a_src_if #(
  parameter int unsigned N = 32'd1
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         r_o;
  logic         a_o;
  logic [N-1:0] d_o;

  modport master (
    input  in_valid, in_data, a_o,
    output in_ready, r_o, d_o
  );

  modport slave (
    output in_valid, in_data, a_o,
    input  in_ready, r_o, d_o
  );
endinterface

// File: rtl/s2a_src.sv
// Valid/ready stream to 4-phase bundled-data source: FIFO, setup timer before
// r_o, and a synchronised acknowledge driving a registered-output FSM.
module s2a_src #(
  parameter logic        Rpol  = 1'b0,
  parameter int unsigned N     = 32'd1,
  parameter int unsigned DEPTH = 32'd4,
  parameter int unsigned SETUP = 32'd2,
  parameter int unsigned SYNC  = 32'd2
) (
  input  logic                   clk,
  input  logic                   rst,
  s2a_src_if.master              bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(SETUP) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_REQ, S_RTZ} state_t;

  state_t                  state;
  logic [DEPTH-1:0][N-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [SW-1:0]           setup_cnt;
  logic [SYNC-1:0]         sync_q;
  logic                    push, pop, ack_act;

  assign bus.in_ready = !rst && (count != CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == S_IDLE) && (count != '0);
  assign ack_act      = sync_q[SYNC-1] ^ Rpol;

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= {SYNC{Rpol}};
    else     sync_q <= {sync_q[SYNC-2:0], bus.a_o};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bus.r_o   <= Rpol;
      bus.d_o   <= '0;
      setup_cnt <= '0;
      err       <= 1'b0;
    end else begin
      // An acknowledge before any request is a consumer fault; flag only.
      if (ack_act && (state == S_IDLE || state == S_SETUP)) err <= 1'b1;
      case (state)
        S_IDLE: if (pop) begin
          bus.d_o   <= mem[rd_ptr];
          setup_cnt <= SW'(SETUP - 1);
          state     <= S_SETUP;
        end
        S_SETUP: if (setup_cnt == '0) begin
          bus.r_o <= ~Rpol;
          state   <= S_REQ;
        end else begin
          setup_cnt <= setup_cnt - SW'(1);
        end
        S_REQ: if (ack_act) begin
          bus.r_o <= Rpol;
          state   <= S_RTZ;
        end
        S_RTZ: if (!ack_act) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
